// File: rtl/veriexp_pkg.sv
// Shared types and defaults for the f_call_arbiter call-sharing block.
package veriexp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } call_state_t;

    localparam int DEFAULT_N = 4;
    localparam int DEFAULT_W = 32;

    // Timeout counter width: enough to hold the limit, kept within 8..32 bits.
    function automatic int cnt_width(input int limit);
        int w;
        w = $clog2(limit + 1);
        if (w < 8) w = 8;
        if (w > 32) w = 32;
        return w;
    endfunction

endpackage

// File: rtl/f_call_arbiter_rr_arbiter.sv
// Combinational round-robin picker: lowest requesting index at or above pointer, wrapping at N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] pointer,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    always_comb begin
        logic found;
        int   j;
        found = 1'b0;
        j     = 0;
        grant = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            j = (int'(pointer) + k) % N;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/f_call_arbiter.sv
// Shares one start/done callee among N requesters with round-robin arbitration.
// Optional WAIT-state timeout is enabled by defining CALL_TIMEOUT_EN.
module f_call_arbiter
    import veriexp_pkg::*;
#(
    parameter int N              = DEFAULT_N,
    parameter int W              = DEFAULT_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   rsp_valid,
    output logic [W-1:0]   rsp_result,
    output logic [N-1:0]   rsp_err,
    output logic           busy,
    output logic           f_start,
    output logic [W-1:0]   f_a,
    output logic [W-1:0]   f_b,
    input  logic [W-1:0]   f_result,
    input  logic           f_done
);

    localparam int IW = $clog2(N);

    call_state_t   state_reg, state_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic [IW-1:0] ptr_reg, ptr_next;
    logic [N-1:0]  gnt_reg, gnt_next;
    logic [N-1:0]  rsp_valid_reg, rsp_valid_next;
    logic [N-1:0]  rsp_err_reg, rsp_err_next;
    logic [W-1:0]  result_reg, result_next;
    logic [W-1:0]  f_a_reg, f_a_next;
    logic [W-1:0]  f_b_reg, f_b_next;
    logic          f_start_reg, f_start_next;

    logic [N-1:0]  arb_grant;
    logic [IW-1:0] arb_idx;
    logic [N-1:0]  idx_onehot;
    logic [W-1:0]  a_slice [N];
    logic [W-1:0]  b_slice [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slice
            assign a_slice[gi] = req_a[gi*W +: W];
            assign b_slice[gi] = req_b[gi*W +: W];
        end
    endgenerate

    rr_arbiter #(.N(N), .IW(IW)) u_rr (
        .req     (req),
        .pointer (ptr_reg),
        .grant   (arb_grant),
        .idx     (arb_idx)
    );

    assign idx_onehot = {{(N-1){1'b0}}, 1'b1} << idx_reg;

`ifdef CALL_TIMEOUT_EN
    localparam int CW = cnt_width(TIMEOUT_CYCLES);
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          timeout_hit;

    // Fires on the TIMEOUT_CYCLES-th WAIT cycle without a done.
    assign timeout_hit = (cnt_reg == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_reg <= '0;
        else        cnt_reg <= cnt_next;
    end
`endif

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        ptr_next       = ptr_reg;
        result_next    = result_reg;
        f_a_next       = f_a_reg;
        f_b_next       = f_b_reg;
        gnt_next       = '0;
        rsp_valid_next = '0;
        rsp_err_next   = '0;
        f_start_next   = 1'b0;
`ifdef CALL_TIMEOUT_EN
        cnt_next       = cnt_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    idx_next     = arb_idx;
                    f_a_next     = a_slice[arb_idx];
                    f_b_next     = b_slice[arb_idx];
                    gnt_next     = arb_grant;
                    f_start_next = 1'b1;
                    state_next   = ISSUE;
                end
            end
            ISSUE: begin
`ifdef CALL_TIMEOUT_EN
                cnt_next   = '0;
`endif
                state_next = WAIT;
            end
            WAIT: begin
                if (f_done) begin
                    result_next    = f_result;
                    rsp_valid_next = idx_onehot;
                    state_next     = RESP;
`ifdef CALL_TIMEOUT_EN
                end else if (timeout_hit) begin
                    result_next    = '0;
                    rsp_valid_next = idx_onehot;
                    rsp_err_next   = idx_onehot;
                    state_next     = RESP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
`endif
                end
            end
            RESP: begin
                ptr_next   = (idx_reg == IW'(N - 1)) ? '0 : idx_reg + 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            ptr_reg       <= '0;
            gnt_reg       <= '0;
            rsp_valid_reg <= '0;
            rsp_err_reg   <= '0;
            result_reg    <= '0;
            f_a_reg       <= '0;
            f_b_reg       <= '0;
            f_start_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            ptr_reg       <= ptr_next;
            gnt_reg       <= gnt_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_err_reg   <= rsp_err_next;
            result_reg    <= result_next;
            f_a_reg       <= f_a_next;
            f_b_reg       <= f_b_next;
            f_start_reg   <= f_start_next;
        end
    end

    assign gnt        = gnt_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_err    = rsp_err_reg;
    assign rsp_result = result_reg;
    assign f_a        = f_a_reg;
    assign f_b        = f_b_reg;
    assign f_start    = f_start_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_f_call_arbiter.sv
// Directed bench for f_call_arbiter with a response scoreboard; define CALL_TIMEOUT_EN to exercise the timeout path.
module tb_f_call_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_result;
    logic [N-1:0]   rsp_err;
    logic           busy;
    logic           f_start;
    logic [W-1:0]   f_a;
    logic [W-1:0]   f_b;
    logic [W-1:0]   f_result;
    logic           f_done;

    typedef struct {
        logic [N-1:0] onehot;
        logic [W-1:0] result;
        logic [N-1:0] err;
    } exp_t;

    exp_t sb_q[$];
    int   total_cnt = 0;
    int   fail_cnt  = 0;

    always #5 clk = ~clk;

    f_call_arbiter #(.N(N), .W(W), .TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_a      (req_a),
        .req_b      (req_b),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .f_start    (f_start),
        .f_a        (f_a),
        .f_b        (f_b),
        .f_result   (f_result),
        .f_done     (f_done)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total_cnt++;
        assert (obs === expv) else begin
            fail_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance to the next falling edge; any response is popped against the scoreboard.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (rsp_valid !== '0) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rsp", 64'(rsp_valid), 64'h0);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_valid", 64'(rsp_valid), 64'(e.onehot));
                chk("rsp_result", 64'(rsp_result), 64'(e.result));
                chk("rsp_err", 64'(rsp_err), 64'(e.err));
            end
        end
    endtask

    // One complete call: callee raises done lat cycles after it sees start.
    task automatic do_call(input logic [N-1:0] mask, input logic [N-1:0] hold, input int exp_idx,
                           input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] res,
                           input int lat, input bit done_in_issue);
        logic [N-1:0] oh;
        oh = N'(1) << exp_idx;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = a ^ (32'h0101_0000 * (i + 1));
            req_b[i*W +: W] = b ^ (32'h0202_0000 * (i + 1));
        end
        req_a[exp_idx*W +: W] = a;
        req_b[exp_idx*W +: W] = b;
        req = mask;
        tick();
        chk("gnt", 64'(gnt), 64'(oh));
        chk("f_start", 64'(f_start), 64'h1);
        chk("f_a", 64'(f_a), 64'(a));
        chk("f_b", 64'(f_b), 64'(b));
        req   = hold;
        req_a = ~req_a;
        req_b = ~req_b;
        sb_q.push_back('{oh, res, '0});
        if (done_in_issue) begin
            f_done   = 1'b1;
            f_result = 32'hdead_beef;
        end
        for (int k = 0; k < lat; k++) begin
            tick();
            f_done = 1'b0;
            if (k == 0) chk("f_start_pulse", 64'(f_start), 64'h0);
        end
        tick();
        chk("no_early_rsp", 64'(sb_q.size()), 64'h1);
        f_done   = 1'b1;
        f_result = res;
        tick();
        f_done = 1'b0;
        chk("rsp_latency", 64'(sb_q.size()), 64'h0);
        chk("f_a_stable", 64'(f_a), 64'(a));
        tick();
        chk("idle_after_resp", 64'(busy), 64'h0);
    endtask

    initial begin
        int waited;
        req      = '0;
        req_a    = '0;
        req_b    = '0;
        f_result = '0;
        f_done   = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_f_start", 64'(f_start), 64'h0);
        chk("rst_rsp_result", 64'(rsp_result), 64'h0);
        rst_n = 1'b1;
        tick();

        // single call, callee returns a
        do_call(4'b0001, 4'b0000, 0, 32'd7, 32'd9, 32'd7, 2, 1'b0);

        // stray done in IDLE
        f_done   = 1'b1;
        f_result = 32'h0bad;
        tick();
        f_done = 1'b0;
        chk("stray_idle_busy", 64'(busy), 64'h0);
        tick();
        chk("stray_idle_busy2", 64'(busy), 64'h0);

        // stray done during ISSUE
        do_call(4'b0010, 4'b0000, 1, 32'h1234, 32'h55, 32'h1234 + 32'h55, 3, 1'b1);

        // reset while waiting: pointer is 2, req 0001 wraps to 0
        req             = 4'b0001;
        req_a[0 +: W]   = 32'hcafe;
        tick();
        chk("pre_rst_gnt", 64'(gnt), 64'h1);
        req = '0;
        tick();
        tick();
        chk("pre_rst_busy", 64'(busy), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 64'(busy), 64'h0);
        chk("async_rst_gnt", 64'(gnt), 64'h0);
        chk("async_rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("async_rst_f_start", 64'(f_start), 64'h0);
        chk("async_rst_rsp_result", 64'(rsp_result), 64'h0);
        chk("async_rst_f_a", 64'(f_a), 64'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        f_done   = 1'b1;
        f_result = 32'hfeed;
        tick();
        f_done = 1'b0;
        chk("late_done_busy", 64'(busy), 64'h0);
        chk("late_done_rsp", 64'(rsp_valid), 64'h0);
        tick();
        chk("late_done_rsp2", 64'(rsp_valid), 64'h0);

        // contention: all four requesting continuously
        for (int k = 0; k < 5; k++) begin
            do_call(4'b1111, 4'b1111, k % 4, 32'h100 + k, 32'h200 + k,
                    (32'h100 + k) + (32'h200 + k), 1 + (k % 2), 1'b0);
        end
        req = '0;
        tick();

        // pointer wrap
        do_call(4'b1000, 4'b0000, 3, 32'h31, 32'h32, 32'h63, 1, 1'b0);
        do_call(4'b1001, 4'b0000, 0, 32'h41, 32'h42, 32'h83, 1, 1'b0);
        do_call(4'b1001, 4'b0000, 3, 32'h51, 32'h52, 32'ha3, 2, 1'b0);

        // callee that never answers (pointer 0, req 0100 -> idx 2)
        req           = 4'b0100;
        req_a[2*W +: W] = 32'h99;
        tick();
        chk("hang_gnt", 64'(gnt), 64'h4);
        req = '0;
`ifdef CALL_TIMEOUT_EN
        sb_q.push_back('{4'b0100, 32'h0, 4'b0100});
        waited = 0;
        while (sb_q.size() != 0 && waited < 40) begin
            tick();
            waited++;
        end
        chk("timeout_seen", 64'(sb_q.size()), 64'h0);
        chk("timeout_latency", 64'(waited), 64'd5);
        tick();
        f_done   = 1'b1;
        f_result = 32'h77;
        tick();
        f_done = 1'b0;
        chk("post_timeout_busy", 64'(busy), 64'h0);
        tick();
        chk("post_timeout_rsp", 64'(rsp_valid), 64'h0);
`else
        sb_q.push_back('{4'b0100, 32'h77, 4'b0000});
        waited = 0;
        repeat (20) begin
            tick();
            waited++;
        end
        chk("wait_persists", 64'(busy), 64'h1);
        chk("wait_no_err", 64'(rsp_err), 64'h0);
        chk("wait_no_rsp", 64'(sb_q.size()), 64'h1);
        f_done   = 1'b1;
        f_result = 32'h77;
        tick();
        f_done = 1'b0;
        chk("late_rsp_seen", 64'(sb_q.size()), 64'h0);
        tick();
`endif

        // next call proceeds normally; pointer is 3, so 0001 wraps to 0
        do_call(4'b0001, 4'b0000, 0, 32'hffff_ffff, 32'h8000_0000, 32'h7fff_ffff, 1, 1'b0);

        chk("sb_empty", 64'(sb_q.size()), 64'h0);
        $display("%0d/%0d checks passed", total_cnt - fail_cnt, total_cnt);
        $finish;
    end

endmodule
